instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 92 +++++++++
 tb/tb_instruction_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, drives a combinational-read instruction
// memory and registers one instruction per cycle toward decode with stall/redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_en,
    output logic [31:0] im_address,
    input  logic [31:0] im_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic        misalign_err
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0] pc_reg,       pc_next;
    logic        valid_reg,    valid_next;
    logic [31:0] instr_reg,    instr_next;
    logic [31:0] if_pc_reg,    if_pc_next;
    logic        fault_reg,    fault_next;
    logic        misalign_reg, misalign_next;

    logic [31:0] word_index;
    logic        out_of_range;
    logic        advance;

    assign word_index   = {2'b00, pc_reg[31:2]};
    assign out_of_range = (word_index >= IMEM_LIMIT);
    assign advance      = !valid_reg || id_ready;

    always_comb begin
        pc_next       = pc_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        if_pc_next    = if_pc_reg;
        fault_next    = 1'b0;
        misalign_next = 1'b0;
        if (redirect) begin
            // The low address bits are dropped; the error pulse reports that they were set.
            pc_next       = {redirect_pc[31:2], 2'b00};
            valid_next    = 1'b0;
            instr_next    = NOP_INSTR;
            misalign_next = (redirect_pc[1:0] != 2'b00);
        end else if (advance) begin
            if_pc_next = pc_reg;
            valid_next = 1'b1;
            pc_next    = pc_reg + 32'd4;
            if (out_of_range) begin
                instr_next = NOP_INSTR;
                fault_next = 1'b1;
            end else begin
                instr_next = im_inst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            if_pc_reg    <= RESET_PC;
            fault_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            if_pc_reg    <= if_pc_next;
            fault_reg    <= fault_next;
            misalign_reg <= misalign_next;
        end
    end

    assign im_en        = !rst;
    assign im_address   = word_index;
    assign if_valid     = valid_reg;
    assign if_instr     = instr_reg;
    assign if_pc        = if_pc_reg;
    assign fetch_fault  = fault_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory holds 32'h1000+k at word k,
// each step checks the registered outputs 1 ns after the rising edge.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_en;
    logic [31:0] im_address;
    logic [31:0] im_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Out-of-range reads return junk so a captured NOP proves the fault path.
    assign im_inst = (im_address < 32'd32) ? (32'h1000 + im_address) : 32'hDEAD_BEEF;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(32),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_en       (im_en),
        .im_address  (im_address),
        .im_inst     (im_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .fetch_fault (fetch_fault),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic ff, input logic me);
        chk({tag, ".valid"},    32'(if_valid),     32'(v));
        chk({tag, ".pc"},       if_pc,             pc);
        chk({tag, ".instr"},    if_instr,          ins);
        chk({tag, ".fault"},    32'(fetch_fault),  32'(ff));
        chk({tag, ".misalign"}, 32'(misalign_err), 32'(me));
        $display("step %-10s valid=%0b pc=%h instr=%h fault=%0b misalign=%0b im_addr=%0d",
                 tag, if_valid, if_pc, if_instr, fetch_fault, misalign_err, im_address);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        chk("reset.im_en", 32'(im_en), 32'd0);

        rst = 1'b0; id_ready = 1'b1;
        #1;
        chk("post_rst.im_en", 32'(im_en), 32'd1);
        chk("post_rst.im_addr", im_address, 32'd0);

        step(); chk_out("seq0", 1'b1, 32'h0, 32'h1000, 1'b0, 1'b0);
        step(); chk_out("seq1", 1'b1, 32'h4, 32'h1001, 1'b0, 1'b0);
        step(); chk_out("seq2", 1'b1, 32'h8, 32'h1002, 1'b0, 1'b0);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1'b1, 32'h8, 32'h1002, 1'b0, 1'b0);
            chk("stall.im_addr", im_address, 32'd3);
        end
        id_ready = 1'b1;
        step(); chk_out("release", 1'b1, 32'hC, 32'h1003, 1'b0, 1'b0);

        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        step(); chk_out("redir40", 1'b0, 32'hC, NOP, 1'b0, 1'b0);
        chk("redir40.im_addr", im_address, 32'd16);
        redirect = 1'b0;
        step(); chk_out("tgt40", 1'b1, 32'h40, 32'h1010, 1'b0, 1'b0);

        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h16;
        step(); chk_out("redir16", 1'b0, 32'h40, NOP, 1'b0, 1'b1);
        chk("redir16.im_addr", im_address, 32'd5);
        redirect = 1'b0;
        step(); chk_out("tgt14", 1'b1, 32'h14, 32'h1005, 1'b0, 1'b0);

        redirect = 1'b1; redirect_pc = 32'h7C;
        step(); chk_out("redir7c", 1'b0, 32'h14, NOP, 1'b0, 1'b0);
        redirect = 1'b0;
        step(); chk_out("last", 1'b1, 32'h7C, 32'h101F, 1'b0, 1'b0);
        step(); chk_out("oob80", 1'b1, 32'h80, NOP, 1'b1, 1'b0);
        step(); chk_out("oob84", 1'b1, 32'h84, NOP, 1'b1, 1'b0);

        redirect = 1'b1; redirect_pc = 32'hC;
        step(); chk_out("redirC", 1'b0, 32'h84, NOP, 1'b0, 1'b0);
        redirect = 1'b0; id_ready = 1'b0;
        step(); chk_out("tgtC", 1'b1, 32'hC, 32'h1003, 1'b0, 1'b0);
        step(); chk_out("holdC", 1'b1, 32'hC, 32'h1003, 1'b0, 1'b0);
        rst = 1'b1;
        step(); chk_out("rst_stall", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_stall.im_addr", im_address, 32'd0);
        chk("rst_stall.im_en", 32'(im_en), 32'd1);

        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
        step(); chk_out("rst_redir", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        chk("rst_redir.im_addr", im_address, 32'd0);
        rst = 1'b0; redirect = 1'b0;

        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); chk_out("redir_top", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        redirect = 1'b0;
        step(); chk_out("top", 1'b1, 32'hFFFF_FFFC, NOP, 1'b1, 1'b0);
        chk("wrap.im_addr", im_address, 32'd0);
        step(); chk_out("wrap0", 1'b1, 32'h0, 32'h1000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
